life_gen_engine: RTL and testbench
==================================

Name: life_gen_engine

Overview:
- Reader side of the rotating cell ring.
- Consumes the serial cell stream leaving the ring, one cell per clock. Keeps a 3x3 neighbourhood window in a line-delay shift register and computes the next generation using B3/S23 rules with a dead (non-wrapping) boundary.
- Drives the ring's update path: nxt_bit is the write enable and pipe_out is the new cell value. Also sequences single-step and free-running generations.

Parameters:
X, 8, grid width in cells
Y, 8, grid height in cells
LOG2X, 3, width of x coordinate
LOG2Y, 3, width of y coordinate
GEN_W, 16, width of generation counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
cell_in  in  1  ring output bit; one new cell index per cycle, indices ascending mod X*Y
run  in  1  level; while high, generations repeat back-to-back
step  in  1  one-cycle pulse; requests exactly one generation
nxt_bit  out  1  ring write enable; pipe_out valid
pipe_out  out  1  next-generation value of cell (out_y,out_x)
out_x  out  LOG2X  x of cell being written
out_y  out  LOG2Y  y of cell being written
busy  out  1  high from ARM through end of RUN
gen_done  out  1  one-cycle pulse after last cell of a generation is written
gen_count  out  GEN_W  completed generations, wraps at 2^GEN_W

Behaviour:
- Reset (sync, high) clears all outputs, the window register and gen_count. pos=0, state IDLE. Reset mid-generation abandons the generation: no gen_done, no further nxt_bit.
- pos is the index of the cell on cell_in. It is free-running, increments every cycle and wraps X*Y-1 -> 0, because the ring rotates every cycle.
- Window register sr has 2X+3 bits and shifts cell_in in each cycle. Centre is sr[X+1]. Neighbour taps are sr[0,1,2,X,X+2,2X,2X+1,2X+2].
- State IDLE -> ARM on (step pulse or run high). ARM waits until pos==X*Y-1, then moves to RUN and clears sr so that rows above row 0 read as dead.
- RUN lasts X*Y+X+1 cycles; rc counts 0..X*Y+X.
  - While rc>=X*Y, the bit shifted into sr is forced 0: the rows below row Y-1 are dead. This also prevents already-updated row 0 from being read back.
  - For rc>=X+1, cell k=rc-X-1 is evaluated.
  - Left taps are masked when x(k)==0. Right taps are masked when x(k)==X-1.
  - Neighbour count is 4 bits, range 0..8. next = (cnt==3) | (centre & cnt==2).
- Output timing: nxt_bit, pipe_out, out_x and out_y are registered. They are valid the cycle after cell_in carried index k+X+1. The ring's write tap is therefore X+2 positions behind its read tap.
- nxt_bit is high for exactly X*Y consecutive cycles per generation. out_x/out_y start at 0,0, ascend, and wrap x at X-1.
- After the last write: gen_done pulses, gen_count increments, state -> ARM if run is high, else IDLE. The next generation starts X*Y-(X+1) cycles later, at the pos alignment.
- step during ARM/RUN is ignored. run dropping during RUN completes the current generation and then returns to IDLE.
- Outside RUN, nxt_bit=0 and pipe_out=0. out_x/out_y hold their last value.
- The cursor flip is applied by the ring. A cell flipped in the same cycle it is written takes the flip per ring rules. The engine sees whatever arrives on cell_in.

Decomposition:
- Package life_pkg:
  - state enum (IDLE, ARM, RUN)
  - rule constants BIRTH_CNT=3, SURVIVE_CNT=2
  - localparams CELLS=X*Y, RUN_LEN=X*Y+X+1, WIN_LEN=2X+3
- Sub-module life_rule: combinational. Inputs are the 8 masked neighbours plus centre; output is the next cell value. Shared with any future parallel evaluator.

Test Plan:
- X=Y=8, horizontal blinker at (3,2),(3,3),(3,4) [y,x], step once -> vertical (2,3),(3,3),(4,3); gen_count=1; nxt_bit high exactly 64 cycles.
- 2x2 block at (0,0)-(1,1), run for 3 gens -> unchanged every gen; corner cell never sees wrap neighbours from (7,7).
- Column wrap check: live cells (2,7),(3,7),(4,7) -> next is (3,6),(3,7) plus none at x=0; row 3 col 0 stays 0.
- Glider from (0,1),(1,2),(2,0),(2,1),(2,2), run 4 gens -> same shape shifted +1,+1; gen_done pulses 4 times, spacing 64+X*Y... i.e. 128 cycles.
- step asserted mid-RUN -> ignored, still gen_count=1; run deasserted mid-RUN -> current gen completes, busy drops, IDLE.
- reset asserted at rc=30 -> next cycle nxt_bit=0, gen_count=0, busy=0; a subsequent step produces a correct generation.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life generation engine.
// Grid defaults match the 8x8 ring; modules derive their own sizes from parameters.
package life_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic [3:0] BIRTH_CNT   = 4'd3;
   localparam logic [3:0] SURVIVE_CNT = 4'd2;

   localparam int GRID_X  = 8;
   localparam int GRID_Y  = 8;
   localparam int CELLS   = GRID_X * GRID_Y;
   localparam int RUN_LEN = CELLS + GRID_X + 1;
   localparam int WIN_LEN = 2 * GRID_X + 3;

endpackage

// File: rtl/life_rule.sv
// B3/S23 cell rule: next value of one cell from its 8 (already masked) neighbours.
module life_rule
   import life_pkg::*;
(
   input  logic [7:0] nbr,
   input  logic       centre,
   output logic       alive
);

   logic [3:0] cnt;

   always_comb begin
      cnt = '0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b000, nbr[i]};
      end
   end

   assign alive = (cnt == BIRTH_CNT) | (centre & (cnt == SURVIVE_CNT));

endmodule

// File: rtl/life_gen_engine.sv
// Reader side of the rotating cell ring: windows the serial cell stream,
// evaluates the next generation and drives the ring's write path.
//
// state | meaning
// IDLE  | no generation pending; waits for step pulse or run level
// ARM   | generation requested; waits for the ring to reach the last cell
// RUN   | streaming one full rotation plus X+1 cells; writes X*Y results
module life_gen_engine
   import life_pkg::*;
#(
   parameter int X     = GRID_X,
   parameter int Y     = GRID_Y,
   parameter int LOG2X = 3,
   parameter int LOG2Y = 3,
   parameter int GEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cell_in,
   input  logic             run,
   input  logic             step,
   output logic             nxt_bit,
   output logic             pipe_out,
   output logic [LOG2X-1:0] out_x,
   output logic [LOG2Y-1:0] out_y,
   output logic             busy,
   output logic             gen_done,
   output logic [GEN_W-1:0] gen_count
);

   localparam int CELL_N = X * Y;
   localparam int RUN_N  = CELL_N + X + 1;
   localparam int WIN_N  = 2 * X + 3;
   localparam int POS_W  = LOG2X + LOG2Y;
   localparam int RC_W   = $clog2(RUN_N);

   localparam logic [POS_W-1:0] POS_LAST = POS_W'(CELL_N - 1);
   localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RUN_N - 1);
   localparam logic [RC_W-1:0]  RC_EVAL  = RC_W'(X + 1);
   localparam logic [RC_W-1:0]  RC_TAIL  = RC_W'(CELL_N);
   localparam logic [LOG2X-1:0] X_LAST   = LOG2X'(X - 1);

   state_t           state;
   state_t           state_nxt;
   logic [POS_W-1:0] pos;
   logic [RC_W-1:0]  rc;
   // The newest window bit is cell_in itself, so only 2X+2 bits are stored.
   logic [WIN_N-2:0] sr;
   logic [WIN_N-1:0] win;
   logic             in_bit;
   logic             evaluate;
   logic             fin;
   logic             rule_out;
   logic [POS_W-1:0] k;
   logic [LOG2X-1:0] kx;
   logic [LOG2Y-1:0] ky;
   logic             edge_l;
   logic             edge_r;
   logic [7:0]       nbr;

   assign in_bit   = ((state == RUN) && (rc >= RC_TAIL)) ? 1'b0 : cell_in;
   assign win      = {sr, in_bit};
   assign evaluate = (state == RUN) && (rc >= RC_EVAL);
   assign k        = POS_W'(rc - RC_EVAL);
   assign kx       = k[LOG2X-1:0];
   assign ky       = k[POS_W-1:LOG2X];
   assign edge_l   = (kx == '0);
   assign edge_r   = (kx == X_LAST);
   assign busy     = (state != IDLE);

   // Taps: row above at 2X..2X+2, own row at X..X+2, row below at 0..2.
   assign nbr = {win[2*X+2] & ~edge_l, win[2*X+1], win[2*X] & ~edge_r,
                 win[X+2]   & ~edge_l,              win[X]   & ~edge_r,
                 win[2]     & ~edge_l, win[1],      win[0]   & ~edge_r};

   life_rule u_rule (
      .nbr    (nbr),
      .centre (win[X+1]),
      .alive  (rule_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (step || run)      state_nxt = ARM;
         ARM:  if (pos == POS_LAST)  state_nxt = RUN;
         RUN:  if (rc == RC_LAST)    state_nxt = run ? ARM : IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos       <= '0;
         rc        <= '0;
         sr        <= '0;
         nxt_bit   <= 1'b0;
         pipe_out  <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         fin       <= 1'b0;
         gen_done  <= 1'b0;
         gen_count <= '0;
      end else begin
         pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
         rc  <= (state == RUN) ? rc + 1'b1 : '0;
         // Clearing on entry to RUN makes the rows above row 0 read as dead.
         sr  <= ((state == ARM) && (pos == POS_LAST)) ? '0 : win[WIN_N-2:0];

         nxt_bit  <= evaluate;
         pipe_out <= evaluate & rule_out;
         if (evaluate) begin
            out_x <= kx;
            out_y <= ky;
         end

         fin      <= (state == RUN) && (rc == RC_LAST);
         gen_done <= fin;
         if (fin) begin
            gen_count <= gen_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_life_gen_engine.sv
// Bench for life_gen_engine: models the rotating ring and checks each
// generation against a plain B3/S23 grid evaluation.
module tb_life_gen_engine;
   import life_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cell_in;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic        nxt_bit, pipe_out, busy, gen_done;
   logic [2:0]  out_x, out_y;
   logic [15:0] gen_count;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          exp_count = 0;
   logic [63:0] ring_q = '0;
   logic [63:0] load_img = '0;
   bit          load_req = 1'b0;
   logic [5:0]  tpos = '0;

   always #5 clk = ~clk;

   life_gen_engine #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .GEN_W(16)) dut (
      .clk(clk), .reset(reset), .cell_in(cell_in), .run(run), .step(step),
      .nxt_bit(nxt_bit), .pipe_out(pipe_out), .out_x(out_x), .out_y(out_y),
      .busy(busy), .gen_done(gen_done), .gen_count(gen_count)
   );

   // Ring model: read tap follows the rotation, write tap takes the engine's results.
   assign cell_in = ring_q[tpos];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      tpos <= reset ? 6'd0 : tpos + 6'd1;
      if (load_req) ring_q <= load_img;
      else if (nxt_bit === 1'b1) ring_q[{out_y, out_x}] <= pipe_out;
   end

   function automatic logic [63:0] bitc(input int y, input int x);
      logic [63:0] v;
      v = '0;
      v[y*8+x] = 1'b1;
      return v;
   endfunction

   function automatic logic [63:0] life_next(input logic [63:0] g);
      logic [63:0] r;
      int n;
      r = '0;
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            n = 0;
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++)
                  if ((dy != 0 || dx != 0) && y+dy >= 0 && y+dy < 8 && x+dx >= 0 && x+dx < 8)
                     n += int'(g[(y+dy)*8 + x+dx]);
            r[y*8+x] = (n == 3) || (g[y*8+x] && n == 2);
         end
      end
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      exp_count = 0;
   endtask

   task automatic load(input logic [63:0] img);
      load_img = img;
      load_req = 1'b1;
      tick(1);
      load_req = 1'b0;
   endtask

   task automatic pulse_step();
      step = 1'b1;
      tick(1);
      step = 1'b0;
   endtask

   // Observes one generation up to its gen_done (or a cycle budget) and tallies what it saw.
   task automatic watch_gen(input logic [63:0] exp, output int writes, output int bad_xy,
                            output int bad_val, output int first_w, output int last_w,
                            output bit done, output int done_cyc);
      writes = 0; bad_xy = 0; bad_val = 0; first_w = -1; last_w = -1;
      done = 1'b0; done_cyc = -1;
      for (int c = 0; c < 3*RUN_LEN + 2*CELLS && !done; c++) begin
         @(negedge clk);
         if (nxt_bit === 1'b1) begin
            if ({out_y, out_x} != writes[5:0]) bad_xy++;
            if (pipe_out !== exp[{out_y, out_x}]) bad_val++;
            if (first_w < 0) first_w = cyc;
            last_w = cyc;
            writes++;
         end
         if (gen_done === 1'b1) begin
            done = 1'b1;
            done_cyc = cyc;
         end
      end
   endtask

   // Counts nxt_bit, busy and gen_done cycles over a quiet window.
   task automatic watch_idle(input int n, output int nxt_hi, output int busy_hi, output int done_hi);
      nxt_hi = 0; busy_hi = 0; done_hi = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (nxt_bit !== 1'b0) nxt_hi++;
         if (busy !== 1'b0) busy_hi++;
         if (gen_done !== 1'b0) done_hi++;
      end
   endtask

   int wr, bxy, bval, fw, lw, dcyc, prev_dcyc, nh, bh, dh;
   bit dn;
   logic [63:0] exp_g;

   task automatic test_reset();
      do_reset();
      n_checks++; if (nxt_bit !== 1'b0) begin n_fail++; $display("FAIL reset_nxt_bit: got %b want 0", nxt_bit); end
      n_checks++; if (pipe_out !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_out: got %b want 0", pipe_out); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (gen_done !== 1'b0) begin n_fail++; $display("FAIL reset_gen_done: got %b want 0", gen_done); end
      n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("FAIL reset_gen_count: got %0d want 0", gen_count); end
      n_checks++; if ({out_y, out_x} !== 6'd0) begin n_fail++; $display("FAIL reset_out_xy: got %0d,%0d want 0,0", out_y, out_x); end
      watch_idle(150, nh, bh, dh);
      n_checks++; if (nh + bh + dh != 0) begin n_fail++; $display("FAIL idle_quiet: got nxt=%0d busy=%0d done=%0d want 0", nh, bh, dh); end
   endtask

   task automatic test_blinker();
      load(bitc(3,2) | bitc(3,3) | bitc(3,4));
      exp_g = life_next(ring_q);
      pulse_step();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL blinker_busy_arm: got %b want 1", busy); end
      watch_gen(exp_g, wr, bxy, bval, fw, lw, dn, dcyc);
      exp_count++;
      n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL blinker_done: got %b want 1", dn); end
      n_checks++; if (wr != CELLS || lw - fw + 1 != CELLS) begin n_fail++; $display("FAIL blinker_writes: got %0d span %0d want %0d", wr, lw-fw+1, CELLS); end
      n_checks++; if (bxy != 0) begin n_fail++; $display("FAIL blinker_coords: got %0d bad want 0", bxy); end
      n_checks++; if (bval != 0) begin n_fail++; $display("FAIL blinker_values: got %0d bad want 0", bval); end
      n_checks++; if (dcyc != lw + 1) begin n_fail++; $display("FAIL blinker_done_timing: got %0d want %0d", dcyc, lw+1); end
      n_checks++; if (ring_q !== (bitc(2,3) | bitc(3,3) | bitc(4,3))) begin n_fail++; $display("FAIL blinker_grid: got %h want %h", ring_q, bitc(2,3)|bitc(3,3)|bitc(4,3)); end
      n_checks++; if (gen_count !== 16'(exp_count)) begin n_fail++; $display("FAIL blinker_gen_count: got %0d want %0d", gen_count, exp_count); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL blinker_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_block_run();
      load(bitc(0,0) | bitc(0,1) | bitc(1,0) | bitc(1,1));
      run = 1'b1;
      prev_dcyc = -1;
      for (int g = 0; g < 3; g++) begin
         if (g == 2) run = 1'b0;
         exp_g = life_next(ring_q);
         watch_gen(exp_g, wr, bxy, bval, fw, lw, dn, dcyc);
         exp_count++;
         n_checks++; if (dn !== 1'b1 || wr != CELLS || bval != 0) begin n_fail++; $display("FAIL block_gen%0d: got done=%b writes=%0d bad=%0d want 1,%0d,0", g, dn, wr, bval, CELLS); end
         n_checks++; if (ring_q !== (bitc(0,0)|bitc(0,1)|bitc(1,0)|bitc(1,1))) begin n_fail++; $display("FAIL block_grid%0d: got %h", g, ring_q); end
         if (g > 0) begin
            n_checks++; if (dcyc - prev_dcyc != 2*CELLS) begin n_fail++; $display("FAIL block_spacing%0d: got %0d want %0d", g, dcyc-prev_dcyc, 2*CELLS); end
         end
         prev_dcyc = dcyc;
      end
      watch_idle(200, nh, bh, dh);
      n_checks++; if (nh + bh + dh != 0) begin n_fail++; $display("FAIL block_stops: got nxt=%0d busy=%0d done=%0d want 0", nh, bh, dh); end
      n_checks++; if (gen_count !== 16'(exp_count)) begin n_fail++; $display("FAIL block_gen_count: got %0d want %0d", gen_count, exp_count); end
   endtask

   task automatic test_column_edge();
      load(bitc(2,7) | bitc(3,7) | bitc(4,7));
      exp_g = life_next(ring_q);
      pulse_step();
      watch_gen(exp_g, wr, bxy, bval, fw, lw, dn, dcyc);
      exp_count++;
      n_checks++; if (dn !== 1'b1 || bval != 0) begin n_fail++; $display("FAIL column_values: got done=%b bad=%0d want 1,0", dn, bval); end
      n_checks++; if (ring_q !== (bitc(3,6) | bitc(3,7))) begin n_fail++; $display("FAIL column_grid: got %h want %h", ring_q, bitc(3,6)|bitc(3,7)); end
      n_checks++; if ((ring_q & 64'h0101_0101_0101_0101) !== 64'd0) begin n_fail++; $display("FAIL column_no_wrap: got %h want 0", ring_q & 64'h0101_0101_0101_0101); end
   endtask

   task automatic test_glider();
      load(bitc(0,1) | bitc(1,2) | bitc(2,0) | bitc(2,1) | bitc(2,2));
      run = 1'b1;
      prev_dcyc = -1;
      for (int g = 0; g < 4; g++) begin
         if (g == 3) run = 1'b0;
         exp_g = life_next(ring_q);
         watch_gen(exp_g, wr, bxy, bval, fw, lw, dn, dcyc);
         exp_count++;
         n_checks++; if (dn !== 1'b1 || bval != 0 || bxy != 0 || ring_q !== exp_g) begin n_fail++; $display("FAIL glider_gen%0d: got done=%b bad=%0d grid=%h want grid=%h", g, dn, bval, ring_q, exp_g); end
         if (g > 0) begin
            n_checks++; if (dcyc - prev_dcyc != 2*CELLS) begin n_fail++; $display("FAIL glider_spacing%0d: got %0d want %0d", g, dcyc-prev_dcyc, 2*CELLS); end
         end
         prev_dcyc = dcyc;
      end
      n_checks++; if (ring_q !== (bitc(1,2)|bitc(2,3)|bitc(3,1)|bitc(3,2)|bitc(3,3))) begin n_fail++; $display("FAIL glider_shift: got %h want %h", ring_q, bitc(1,2)|bitc(2,3)|bitc(3,1)|bitc(3,2)|bitc(3,3)); end
      tick(WIN_LEN);
      n_checks++; if (busy !== 1'b0 || gen_count !== 16'(exp_count)) begin n_fail++; $display("FAIL glider_end: got busy=%b count=%0d want 0,%0d", busy, gen_count, exp_count); end
   endtask

   task automatic test_mid_run_controls();
      do_reset();
      load(bitc(3,2) | bitc(3,3) | bitc(3,4) | bitc(6,6) | bitc(6,7) | bitc(7,6));
      exp_g = life_next(ring_q);
      pulse_step();
      fork
         watch_gen(exp_g, wr, bxy, bval, fw, lw, dn, dcyc);
         begin
            for (int c = 0; c < 200 && nxt_bit !== 1'b1; c++) @(negedge clk);
            tick(20);
            pulse_step();
         end
      join
      exp_count++;
      n_checks++; if (dn !== 1'b1 || wr != CELLS || bval != 0) begin n_fail++; $display("FAIL step_mid_gen: got done=%b writes=%0d bad=%0d want 1,%0d,0", dn, wr, bval, CELLS); end
      watch_idle(300, nh, bh, dh);
      n_checks++; if (nh + bh + dh != 0 || gen_count !== 16'd1) begin n_fail++; $display("FAIL step_ignored: got nxt=%0d busy=%0d count=%0d want 0,0,1", nh, bh, gen_count); end

      exp_g = life_next(ring_q);
      run = 1'b1;
      fork
         watch_gen(exp_g, wr, bxy, bval, fw, lw, dn, dcyc);
         begin
            for (int c = 0; c < 200 && nxt_bit !== 1'b1; c++) @(negedge clk);
            tick(20);
            run = 1'b0;
         end
      join
      exp_count++;
      n_checks++; if (dn !== 1'b1 || wr != CELLS || bval != 0 || ring_q !== exp_g) begin n_fail++; $display("FAIL run_drop_gen: got done=%b writes=%0d bad=%0d want 1,%0d,0", dn, wr, bval, CELLS); end
      watch_idle(300, nh, bh, dh);
      n_checks++; if (nh + bh + dh != 0 || gen_count !== 16'd2) begin n_fail++; $display("FAIL run_drop_idle: got nxt=%0d busy=%0d count=%0d want 0,0,2", nh, bh, gen_count); end
   endtask

   task automatic test_reset_mid_gen();
      bit seen;
      seen = 1'b0;
      pulse_step();
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         if (nxt_bit === 1'b1) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_start: got no write want write"); end
      tick(20);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      exp_count = 0;
      n_checks++; if (nxt_bit !== 1'b0 || busy !== 1'b0 || gen_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_clear: got nxt=%b busy=%b count=%0d want 0,0,0", nxt_bit, busy, gen_count); end
      watch_idle(150, nh, bh, dh);
      n_checks++; if (nh + bh + dh != 0) begin n_fail++; $display("FAIL rstmid_abandon: got nxt=%0d busy=%0d done=%0d want 0", nh, bh, dh); end
      exp_g = life_next(ring_q);
      pulse_step();
      watch_gen(exp_g, wr, bxy, bval, fw, lw, dn, dcyc);
      exp_count++;
      n_checks++; if (dn !== 1'b1 || wr != CELLS || bval != 0 || bxy != 0 || ring_q !== exp_g) begin n_fail++; $display("FAIL rstmid_regen: got done=%b writes=%0d bad=%0d grid=%h want grid=%h", dn, wr, bval, ring_q, exp_g); end
      n_checks++; if (gen_count !== 16'd1) begin n_fail++; $display("FAIL rstmid_count: got %0d want 1", gen_count); end
   endtask

   task automatic test_random();
      logic [63:0] img;
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 64; i++) img[i] = ($urandom_range(0, 2) == 0);
         load(img);
         exp_g = life_next(ring_q);
         pulse_step();
         watch_gen(exp_g, wr, bxy, bval, fw, lw, dn, dcyc);
         exp_count++;
         n_checks++; if (dn !== 1'b1 || wr != CELLS || bval != 0 || bxy != 0) begin n_fail++; $display("FAIL random%0d_stream: got done=%b writes=%0d badxy=%0d badval=%0d", t, dn, wr, bxy, bval); end
         n_checks++; if (ring_q !== exp_g) begin n_fail++; $display("FAIL random%0d_grid: got %h want %h", t, ring_q, exp_g); end
         n_checks++; if (gen_count !== 16'(exp_count)) begin n_fail++; $display("FAIL random%0d_count: got %0d want %0d", t, gen_count, exp_count); end
      end
   endtask

   initial begin
      test_reset();
      test_blinker();
      test_block_run();
      test_column_edge();
      test_glider();
      test_mid_run_controls();
      test_reset_mid_gen();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
